// File: rtl/branch_resolve_queue.sv
// Branch resolution queue: tracks in-flight predicted branches, retires them in order and
// flushes on mispredict. Define BRQ_TRAIN_EN to emit a predictor training packet on every retire.
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_valid,
  input  logic [`XLEN-1:0]   alloc_pc,
  input  logic               alloc_pred_taken,
  input  logic [`XLEN-1:0]   alloc_pred_target,
  output logic               alloc_ready,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               res_valid,
  input  logic [TAG_W-1:0]   res_tag,
  input  logic               res_taken,
  input  logic [`XLEN-1:0]   res_target,
  output logic               mispredict,
  output logic [`XLEN-1:0]   redirect_pc,
  output logic               upd_valid,
  output logic [`XLEN-1:0]   upd_pc,
  output logic               upd_taken,
  output logic [`XLEN-1:0]   upd_target,
  output logic [TAG_W:0]     count
);

  logic [`XLEN-1:0] pc_q          [DEPTH];
  logic [`XLEN-1:0] pred_target_q [DEPTH];
  logic [`XLEN-1:0] res_target_q  [DEPTH];
  logic             pred_taken_q  [DEPTH];
  logic             res_taken_q   [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] resolved;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic             retire;
  logic             retire_ok;
  logic             mis_retire;
  logic             alloc_fire;
  logic             res_fire;
  logic [`XLEN-1:0] correct_pc;

  // Retirement looks only at registered state, so a resolution is visible one cycle later.
  assign retire     = valid[head] & resolved[head];
  assign mis_retire = retire &
                      ((res_taken_q[head] != pred_taken_q[head]) ||
                       (res_taken_q[head] && (res_target_q[head] != pred_target_q[head])));
  assign retire_ok  = retire & ~mis_retire;
  assign correct_pc = res_taken_q[head] ? res_target_q[head]
                                        : pc_q[head] + {{(`XLEN-3){1'b0}}, 3'd4};

  assign alloc_ready = (count != (TAG_W+1)'(DEPTH)) && !mis_retire;
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign res_fire    = res_valid && valid[res_tag] && !mis_retire;

  // NOTE: payload arrays carry no reset; valid/resolved bits alone decide whether they matter.
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      pc_q[tail]          <= alloc_pc;
      pred_taken_q[tail]  <= alloc_pred_taken;
      pred_target_q[tail] <= alloc_pred_target;
    end
    if (res_fire) begin
      res_taken_q[res_tag]  <= res_taken;
      res_target_q[res_tag] <= res_target;
    end
  end

  // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      valid       <= '0;
      resolved    <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict  <= mis_retire;
      redirect_pc <= mis_retire ? correct_pc : '0;
      if (mis_retire) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        valid    <= '0;
        resolved <= '0;
      end else begin
        if (res_fire) resolved[res_tag] <= 1'b1;
        if (alloc_fire) begin
          valid[tail]    <= 1'b1;
          resolved[tail] <= 1'b0;
          tail           <= tail + TAG_W'(1);
        end
        if (retire_ok) begin
          valid[head] <= 1'b0;
          head        <= head + TAG_W'(1);
        end
        case ({alloc_fire, retire_ok})
          2'b10:   count <= count + (TAG_W+1)'(1);
          2'b01:   count <= count - (TAG_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BRQ_TRAIN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
    end else begin
      upd_valid  <= retire;
      upd_pc     <= retire ? pc_q[head] : '0;
      upd_taken  <= retire & res_taken_q[head];
      upd_target <= retire ? correct_pc : '0;
    end
  end
`else
  assign upd_valid  = 1'b0;
  assign upd_pc     = '0;
  assign upd_taken  = 1'b0;
  assign upd_target = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a scoreboard queue holds the expected output
// pulses and every cycle the observed pulse (if any) is popped and compared.
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int XL    = `XLEN;

  logic             clock = 1'b0;
  logic             reset;
  logic             alloc_valid;
  logic [XL-1:0]    alloc_pc;
  logic             alloc_pred_taken;
  logic [XL-1:0]    alloc_pred_target;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic [XL-1:0]    res_target;
  logic             mispredict;
  logic [XL-1:0]    redirect_pc;
  logic             upd_valid;
  logic [XL-1:0]    upd_pc;
  logic             upd_taken;
  logic [XL-1:0]    upd_target;
  logic [TAG_W:0]   count;

  branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
    .alloc_pred_target(alloc_pred_target), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          mis;
    logic [XL-1:0] redirect;
    logic          uv;
    logic [XL-1:0] upc;
    logic          utaken;
    logic [XL-1:0] utarget;
  } pulse_t;

  pulse_t exp_q[$];
  int     total = 0;
  int     bad   = 0;
  bit     train_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output pulse for one retirement; only mispredicts pulse when training is off.
  task automatic push_exp(input logic mis, input logic [XL-1:0] cpc,
                          input logic [XL-1:0] pc, input logic taken);
    pulse_t p;
    if (!mis && !train_en) return;
    p.mis      = mis;
    p.redirect = mis ? cpc : '0;
    p.uv       = train_en;
    p.upc      = train_en ? pc : '0;
    p.utaken   = train_en ? taken : 1'b0;
    p.utarget  = train_en ? cpc : '0;
    exp_q.push_back(p);
  endtask

  task automatic tick();
    pulse_t p;
    @(posedge clock);
    #1;
    if (mispredict === 1'b1 || upd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {mispredict, upd_valid}, 2'b00);
      end else begin
        p = exp_q.pop_front();
        check("pulse_mis",      mispredict,  p.mis);
        check("pulse_redirect", redirect_pc, p.redirect);
        check("pulse_upd_v",    upd_valid,   p.uv);
        check("pulse_upd_pc",   upd_pc,      p.upc);
        check("pulse_upd_tk",   upd_taken,   p.utaken);
        check("pulse_upd_tgt",  upd_target,  p.utarget);
      end
    end else begin
      check("idle_mis",      mispredict,  1'b0);
      check("idle_redirect", redirect_pc, '0);
      check("idle_upd",      {upd_valid, upd_taken}, 2'b00);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_pc = '0; alloc_pred_taken = 0; alloc_pred_target = '0;
    res_valid = 0; res_tag = '0; res_taken = 0; res_target = '0;
  endtask

  task automatic do_alloc(input logic [XL-1:0] pc, input logic pt, input logic [XL-1:0] ptgt);
    alloc_valid = 1; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_target = ptgt;
    tick();
    idle_inputs();
  endtask

  task automatic do_res(input logic [TAG_W-1:0] tag, input logic t, input logic [XL-1:0] tgt);
    res_valid = 1; res_tag = tag; res_taken = t; res_target = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
`ifdef BRQ_TRAIN_EN
    train_en = 1'b1;
`else
    train_en = 1'b0;
`endif
    idle_inputs();
    reset = 1;
    @(posedge clock);
    #1;
    do_reset();
    check("rst_count", count, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_tag",   alloc_tag, 0);

    // Not-taken prediction resolved taken: mispredict to the real target.
    check("s1_tag", alloc_tag, 0);
    do_alloc(32'h100, 0, 32'h0);
    check("s1_count1", count, 1);
    push_exp(1, 32'h200, 32'h100, 1);
    do_res(0, 1, 32'h200);
    check("s1_ready_during_flush", alloc_ready, 0);
    tick();
    check("s1_mis", mispredict, 1);
    check("s1_count0", count, 0);
    tick();
    check("s1_mis_one_cycle", mispredict, 0);

    // Correct taken prediction: no mispredict, optional training pulse.
    do_alloc(32'h40, 1, 32'h80);
    push_exp(0, 32'h80, 32'h40, 1);
    do_res(0, 1, 32'h80);
    tick();
    check("s2_no_mis", mispredict, 0);
    check("s2_count", count, 0);
    check("s2_tag_advanced", alloc_tag, 1);

    // Fill, overflow attempt, then retire+alloc in the same cycle with tail wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check("s3_alloc_tag", alloc_tag, i);
      do_alloc(32'h1000 + 32'(i * 4), 0, 32'h0);
    end
    check("s3_full_ready", alloc_ready, 0);
    check("s3_full_count", count, DEPTH);
    do_alloc(32'hDEAD, 1, 32'hBEEF);
    check("s3_ovf_count", count, DEPTH);
    check("s3_wrap_tag", alloc_tag, 0);
    push_exp(0, 32'h1004, 32'h1000, 0);
    do_res(0, 0, 32'h0);
    check("s3_full_no_alloc", alloc_ready, 0);
    tick();
    check("s3_count7", count, DEPTH - 1);
    push_exp(0, 32'h1008, 32'h1004, 0);
    do_res(1, 0, 32'h0);
    check("s3_ready_retire", alloc_ready, 1);
    check("s3_tag_wrapped", alloc_tag, 0);
    do_alloc(32'h2000, 0, 32'h0);
    check("s3_count_same", count, DEPTH - 1);
    check("s3_tag1", alloc_tag, 1);
    do_alloc(32'h2004, 0, 32'h0);
    check("s3_refull", count, DEPTH);

    // Out-of-order resolution, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(32'h500 + 32'(i * 4), 0, 32'h0);
    do_res(2, 0, 32'h0);
    do_res(1, 0, 32'h0);
    tick();
    check("s4_wait_head", count, 3);
    push_exp(0, 32'h504, 32'h500, 0);
    push_exp(0, 32'h508, 32'h504, 0);
    push_exp(0, 32'h50C, 32'h508, 0);
    do_res(0, 0, 32'h0);
    check("s4_not_yet", count, 3);
    tick();
    check("s4_c2", count, 2);
    tick();
    check("s4_c1", count, 1);
    tick();
    check("s4_c0", count, 0);
    tick();
    check("s4_drained", exp_q.size(), 0);

    // Mid-queue mispredict flushes younger entries; their later resolutions are dropped.
    do_reset();
    do_alloc(32'h2F0, 0, 32'h0);
    do_alloc(32'h300, 1, 32'h400);
    for (int i = 2; i < 5; i++) do_alloc(32'h300 + 32'(i * 4), 0, 32'h0);
    push_exp(0, 32'h2F4, 32'h2F0, 0);
    do_res(0, 0, 32'h0);
    push_exp(1, 32'h304, 32'h300, 0);
    do_res(1, 0, 32'h0);
    check("s5_count4", count, 4);
    do_res(2, 1, 32'h999);
    check("s5_mis", mispredict, 1);
    check("s5_redirect", redirect_pc, 32'h304);
    check("s5_flushed", count, 0);
    do_alloc(32'h700, 1, 32'h800);
    do_res(3, 1, 32'h123);
    do_res(4, 0, 32'h0);
    do_res(2, 0, 32'h0);
    tick();
    tick();
    check("s5_dropped", count, 1);

    // Reset while a mispredicting head is about to retire.
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(32'h900 + 32'(i * 4), 0, 32'h0);
    do_res(0, 1, 32'hA00);
    reset = 1;
    tick();
    check("s6_no_mis", mispredict, 0);
    check("s6_count", count, 0);
    reset = 0;
    tick();
    check("s6_ready", alloc_ready, 1);
    check("s6_no_pulse", {mispredict, upd_valid}, 2'b00);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
